// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Define MDU_DIV0_SHORTCUT_EN to finish a divide by zero in one busy cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mord,
    input  logic        signmd,
    input  logic        weMD,
    input  logic        wHiLo,
    input  logic        rHiLo,
    input  logic        req,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] rdata
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n, div_len;
    logic        op_div, op_sgn, go, commit, we_ok, neg_a, neg_b;
    logic [31:0] ra, rb, hi, lo, ua, ub, uq, ur, q, r;
    logic [63:0] ea, eb, prod;
`ifdef MDU_DIV0_SHORTCUT_EN
    assign div_len = (b == 32'd0) ? 4'd1 : 4'd10;
`else
    assign div_len = 4'd10;
`endif
    assign busy     = state == RUN;
    assign md_stall = start | busy;
    assign rdata    = rHiLo ? lo : hi;
    assign go       = (state == IDLE) && start && !req;
    assign we_ok    = weMD && !req && !busy && !start;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        commit  = 1'b0;
        if (state == IDLE) begin
            state_n = go ? RUN : IDLE;
            cnt_n   = go ? ((mord == 2'b01) ? div_len : 4'd5) : cnt;
        end else begin
            cnt_n   = cnt - 4'd1;
            commit  = cnt == 4'd1;
            state_n = commit ? IDLE : RUN;
        end
    end
    // Extending to 64 bits makes one unsigned multiply serve both signednesses.
    always_comb begin
        ea    = {{32{op_sgn & ra[31]}}, ra};
        eb    = {{32{op_sgn & rb[31]}}, rb};
        prod  = ea * eb;
        neg_a = op_sgn & ra[31];
        neg_b = op_sgn & rb[31];
        ua    = neg_a ? -ra : ra;
        ub    = neg_b ? -rb : rb;
        uq    = (ub == 32'd0) ? 32'd0 : ua / ub;
        ur    = (ub == 32'd0) ? 32'd0 : ua % ub;
        q     = (neg_a ^ neg_b) ? -uq : uq;
        r     = neg_a ? -ur : ur;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            op_div <= 1'b0;
            op_sgn <= 1'b0;
            ra     <= 32'd0;
            rb     <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (go) begin
                op_div <= mord == 2'b01;
                op_sgn <= signmd;
                ra     <= a;
                rb     <= b;
            end
            if (commit && !(op_div && rb == 32'd0)) begin
                hi <= op_div ? r : prod[63:32];
                lo <= op_div ? q : prod[31:0];
            end else if (we_ok) begin
                if (wHiLo) lo <= a;
                else       hi <= a;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, signmd = 1'b0, weMD = 1'b0;
    logic        wHiLo = 1'b0, rHiLo = 1'b0, req = 1'b0;
    logic [1:0]  mord = 2'b00;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        busy, md_stall;
    logic [31:0] rdata;
    int          checks = 0, errors = 0;
    logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;
`ifdef MDU_DIV0_SHORTCUT_EN
    localparam int DIV0_LEN = 1;
`else
    localparam int DIV0_LEN = 10;
`endif
    typedef struct {
        logic [1:0]  m;
        logic        s;
        logic [31:0] x, y, h, l;
        int          len;
    } vec_t;
    vec_t vecs[7];

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .mord(mord), .signmd(signmd),
        .weMD(weMD), .wHiLo(wHiLo), .rHiLo(rHiLo), .req(req), .a(a), .b(b),
        .busy(busy), .md_stall(md_stall), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
        rHiLo = 1'b0;
        #1 h = rdata;
        rHiLo = 1'b1;
        #1 l = rdata;
    endtask

    task automatic model_op(input logic [1:0] m, input logic s, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, qq, rr;
        logic [63:0] p;
        if (m == 2'b01) begin
            if (y != 32'd0) begin
                sx = s ? longint'($signed(x)) : longint'({32'd0, x});
                sy = s ? longint'($signed(y)) : longint'({32'd0, y});
                qq = sx / sy;
                rr = sx % sy;
                exp_lo = qq[31:0];
                exp_hi = rr[31:0];
            end
        end else begin
            sx = s ? longint'($signed(x)) : longint'({32'd0, x});
            sy = s ? longint'($signed(y)) : longint'({32'd0, y});
            p = (s ? sx * sy : {32'd0, x} * {32'd0, y});
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end
    endtask

    function automatic int op_len(input logic [1:0] m, input logic [31:0] y);
        return (m == 2'b01) ? ((y == 32'd0) ? DIV0_LEN : 10) : 5;
    endfunction

    task automatic do_op(input logic [1:0] m, input logic s, input logic [31:0] x, input logic [31:0] y, output int n);
        mord = m; signmd = s; a = x; b = y; start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            n++;
            tick;
        end
    endtask

    task automatic mdu_write(input logic w, input logic [31:0] d);
        weMD = 1'b1; wHiLo = w; a = d;
        tick;
        weMD = 1'b0;
        if (w) exp_lo = d;
        else   exp_hi = d;
    endtask

    task automatic test_reset;
        logic [31:0] h, l;
        reset = 1'b1; start = 1'b1;
        #1;
        checks++;
        if (md_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_eq_start got %b want 1", md_stall); end
        start = 1'b0;
        tick; tick;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", md_stall); end
        read_hl(h, l);
        checks++;
        if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", h, l); end
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_directed;
        logic [31:0] h, l;
        int n;
        vecs[0] = '{2'b00, 1'b1, 32'd7, 32'd6, 32'd0, 32'd42, 5};
        vecs[1] = '{2'b00, 1'b0, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 5};
        vecs[2] = '{2'b00, 1'b1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[3] = '{2'b01, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4] = '{2'b01, 1'b0, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC, 10};
        vecs[5] = '{2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10};
        vecs[6] = '{2'b10, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 5};
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].m, vecs[i].s, vecs[i].x, vecs[i].y, n);
            checks++;
            if (n != vecs[i].len) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d", i, n, vecs[i].len); end
            read_hl(h, l);
            checks++;
            if (h !== vecs[i].h || l !== vecs[i].l) begin
                errors++;
                $display("FAIL directed%0d_hilo got %h/%h want %h/%h", i, h, l, vecs[i].h, vecs[i].l);
            end
            exp_hi = vecs[i].h; exp_lo = vecs[i].l;
        end
    endtask

    task automatic test_div0;
        logic [31:0] h, l;
        int n;
        mdu_write(1'b0, 32'h11);
        mdu_write(1'b1, 32'h22);
        do_op(2'b01, 1'($urandom_range(0, 1)), $urandom, 32'd0, n);
        checks++;
        if (n != DIV0_LEN) begin errors++; $display("FAIL div0_latency got %0d want %0d", n, DIV0_LEN); end
        read_hl(h, l);
        checks++;
        if (h !== 32'h11 || l !== 32'h22) begin errors++; $display("FAIL div0_hilo got %h/%h want 11/22", h, l); end
    endtask

    task automatic test_random;
        logic [31:0] h, l, x, y;
        logic [1:0] m;
        logic s;
        int n, sel;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                mdu_write(1'($urandom_range(0, 1)), $urandom);
            end else begin
                m = 2'($urandom_range(0, 3));
                s = 1'($urandom_range(0, 1));
                x = $urandom;
                sel = $urandom_range(0, 5);
                y = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? 32'($urandom_range(1, 9)) : $urandom;
                model_op(m, s, x, y);
                do_op(m, s, x, y, n);
                checks++;
                if (n != op_len(m, y)) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, n, op_len(m, y)); end
            end
            read_hl(h, l);
            checks++;
            if (h !== exp_hi || l !== exp_lo) begin
                errors++;
                $display("FAIL rand%0d_hilo got %h/%h want %h/%h", i, h, l, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_req_block;
        logic [31:0] h, l;
        int n;
        mord = 2'b00; signmd = 1'b0; a = 32'd5; b = 32'd5; start = 1'b1; req = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL req_start_busy got %b want 0", busy); end
        weMD = 1'b1; wHiLo = 1'b0; a = 32'hDEAD;
        tick;
        weMD = 1'b0; req = 1'b0;
        read_hl(h, l);
        checks++;
        if (h !== exp_hi || l !== exp_lo) begin errors++; $display("FAIL req_hilo got %h/%h want %h/%h", h, l, exp_hi, exp_lo); end
        model_op(2'b01, 1'b0, 32'd100, 32'd7);
        mord = 2'b01; signmd = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        weMD = 1'b1; wHiLo = 1'b0; a = 32'h1234; start = 1'b1; mord = 2'b00; b = 32'd3;
        tick;
        weMD = 1'b0; start = 1'b0; req = 1'b1;
        tick;
        req = 1'b0;
        n = 3;
        while (busy === 1'b1 && n < 30) begin
            n++;
            tick;
        end
        checks++;
        if (n != 10) begin errors++; $display("FAIL busy_ignore_latency got %0d want 10", n); end
        read_hl(h, l);
        checks++;
        if (h !== 32'd2 || l !== 32'd14) begin errors++; $display("FAIL busy_ignore_hilo got %h/%h want 2/e", h, l); end
    endtask

    task automatic test_priority;
        logic [31:0] h, l;
        int n;
        mord = 2'b00; signmd = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1; weMD = 1'b1; wHiLo = 1'b1;
        tick;
        start = 1'b0; weMD = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            n++;
            tick;
        end
        checks++;
        if (n != 5) begin errors++; $display("FAIL priority_latency got %0d want 5", n); end
        read_hl(h, l);
        checks++;
        if (h !== 32'd0 || l !== 32'd15) begin errors++; $display("FAIL priority_hilo got %h/%h want 0/f", h, l); end
        exp_hi = 32'd0; exp_lo = 32'd15;
    endtask

    task automatic test_back_to_back;
        logic [31:0] h, l, x, y;
        int n;
        for (int i = 0; i < 4; i++) begin
            x = $urandom; y = $urandom;
            model_op(2'(i & 1), 1'(i >> 1), x, y);
            do_op(2'(i & 1), 1'(i >> 1), x, y, n);
            checks++;
            if (n != op_len(2'(i & 1), y)) begin errors++; $display("FAIL b2b%0d_latency got %0d want %0d", i, n, op_len(2'(i & 1), y)); end
            read_hl(h, l);
            checks++;
            if (h !== exp_hi || l !== exp_lo) begin errors++; $display("FAIL b2b%0d_hilo got %h/%h want %h/%h", i, h, l, exp_hi, exp_lo); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] h, l;
        mdu_write(1'b0, 32'hAAAA);
        mdu_write(1'b1, 32'h5555);
        mord = 2'b00; signmd = 1'b1; a = 32'd7; b = 32'd6; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b want 0", busy); end
        read_hl(h, l);
        checks++;
        if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL reset_mid_hilo got %h/%h want 0/0", h, l); end
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_div0;
        test_random;
        test_req_block;
        test_priority;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
